// File: rtl/maxpool2x2_layer1_if.sv
// Pixel-stream interface of the layer-1 2x2 pooling stage: 8-channel input beat in,
// pooled 8-channel result and end-of-frame pulse out.
interface maxpool2x2_layer1_if;
  logic       in_valid;
  logic [7:0] in_ch0, in_ch1, in_ch2, in_ch3, in_ch4, in_ch5, in_ch6, in_ch7;
  logic       out_valid;
  logic [7:0] out_pool0, out_pool1, out_pool2, out_pool3;
  logic [7:0] out_pool4, out_pool5, out_pool6, out_pool7;
  logic       frame_done;

  modport master (
    output in_valid, in_ch0, in_ch1, in_ch2, in_ch3, in_ch4, in_ch5, in_ch6, in_ch7,
    input  out_valid, out_pool0, out_pool1, out_pool2, out_pool3,
           out_pool4, out_pool5, out_pool6, out_pool7, frame_done
  );

  modport slave (
    input  in_valid, in_ch0, in_ch1, in_ch2, in_ch3, in_ch4, in_ch5, in_ch6, in_ch7,
    output out_valid, out_pool0, out_pool1, out_pool2, out_pool3,
           out_pool4, out_pool5, out_pool6, out_pool7, frame_done
  );
endinterface

// File: rtl/maxpool2x2_layer1.sv
// 2x2 stride-2 pooling over the 8-channel layer-1 raster stream using one half-width row buffer.
// Define MAXPOOL_AVG_EN to build average pooling instead of max pooling.
module maxpool2x2_layer1 #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned CH    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  maxpool2x2_layer1_if.slave pool_if
);
  localparam int unsigned PIX_W  = 8;
`ifdef MAXPOOL_AVG_EN
  localparam int unsigned ACC_W  = PIX_W + 1;
  localparam int unsigned SUM_W  = ACC_W + 1;
`else
  localparam int unsigned ACC_W  = PIX_W;
`endif
  localparam int unsigned HALF_W = IMG_W / 2;
  localparam int unsigned LAST_C = 2 * HALF_W - 1;
  localparam int unsigned LAST_R = 2 * (IMG_H / 2) - 1;
  localparam int unsigned CW     = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW     = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int unsigned BW     = (HALF_W > 2) ? $clog2(HALF_W) : 1;

  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CH*PIX_W-1:0]    hold_q, hold_d;
  logic [CH*PIX_W-1:0]    pool_q, pool_d;
  logic                   out_valid_q, out_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic [CH*ACC_W-1:0]    rowbuf_q [HALF_W];

  logic [CH*PIX_W-1:0]    in_pix_c;
  logic [CH*ACC_W-1:0]    pair_c;
  logic [CH*ACC_W-1:0]    rb_rd_c;
  logic [CH*PIX_W-1:0]    pooled_c;
  logic [BW-1:0]          rb_idx_c;
  logic                   rb_we_c;
  logic                   in_win_c;

  assign in_pix_c = {pool_if.in_ch7, pool_if.in_ch6, pool_if.in_ch5, pool_if.in_ch4,
                     pool_if.in_ch3, pool_if.in_ch2, pool_if.in_ch1, pool_if.in_ch0};
  assign rb_idx_c = BW'(col_q >> 1);
  assign rb_rd_c  = rowbuf_q[rb_idx_c];
  // Trailing odd column/row of an odd-sized frame falls outside every window.
  assign in_win_c = (32'(col_q) <= LAST_C) && (32'(row_q) <= LAST_R);

  // Horizontal pair from hold + current beat, then vertical combine with the buffered pair.
  always_comb begin
    pair_c   = '0;
    pooled_c = '0;
    for (int unsigned k = 0; k < CH; k++) begin
`ifdef MAXPOOL_AVG_EN
      pair_c[k*ACC_W +: ACC_W]   = ACC_W'(hold_q[k*PIX_W +: PIX_W]) + ACC_W'(in_pix_c[k*PIX_W +: PIX_W]);
      pooled_c[k*PIX_W +: PIX_W] = PIX_W'((SUM_W'(pair_c[k*ACC_W +: ACC_W]) +
                                           SUM_W'(rb_rd_c[k*ACC_W +: ACC_W])) >> 2);
`else
      pair_c[k*ACC_W +: ACC_W]   = (hold_q[k*PIX_W +: PIX_W] > in_pix_c[k*PIX_W +: PIX_W]) ?
                                   hold_q[k*PIX_W +: PIX_W] : in_pix_c[k*PIX_W +: PIX_W];
      pooled_c[k*PIX_W +: PIX_W] = (pair_c[k*ACC_W +: ACC_W] > rb_rd_c[k*ACC_W +: ACC_W]) ?
                                   pair_c[k*ACC_W +: ACC_W] : rb_rd_c[k*ACC_W +: ACC_W];
`endif
    end
  end

  // Raster counters and per-position action: hold (even col), buffer (even row), emit (odd row).
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    pool_d       = pool_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    rb_we_c      = 1'b0;
    if (pool_if.in_valid) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (in_win_c) begin
        if (!col_q[0]) begin
          hold_d = in_pix_c;
        end else if (!row_q[0]) begin
          rb_we_c = 1'b1;
        end else begin
          out_valid_d  = 1'b1;
          pool_d       = pooled_c;
          frame_done_d = (col_q == CW'(LAST_C)) && (row_q == RW'(LAST_R));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      pool_q       <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      pool_q       <= pool_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // No reset needed: each entry is rewritten on an even row before its odd-row read.
  always_ff @(posedge clk) begin
    if (rb_we_c) begin
      rowbuf_q[rb_idx_c] <= pair_c;
    end
  end

  assign pool_if.out_valid  = out_valid_q;
  assign pool_if.frame_done = frame_done_q;
  assign pool_if.out_pool0  = pool_q[7:0];
  assign pool_if.out_pool1  = pool_q[15:8];
  assign pool_if.out_pool2  = pool_q[23:16];
  assign pool_if.out_pool3  = pool_q[31:24];
  assign pool_if.out_pool4  = pool_q[39:32];
  assign pool_if.out_pool5  = pool_q[47:40];
  assign pool_if.out_pool6  = pool_q[55:48];
  assign pool_if.out_pool7  = pool_q[63:56];
endmodule

// File: tb/tb_maxpool2x2_layer1.sv
// Scoreboard bench for maxpool2x2_layer1: 4x4, 28x28 and 5x5 instances driven one at a time.
`timescale 1ns/1ps
module tb_maxpool2x2_layer1;
  typedef struct {
    int          id;
    logic [63:0] data;
    logic        fd;
    int          cyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] chv   = '0;
  logic [2:0]  vld   = '0;
  logic [2:0]  ov, fdo;
  logic [63:0] od [3];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          nout [3] = '{0, 0, 0};
  int          nfd  [3] = '{0, 0, 0};
  logic [63:0] last [3];
  exp_t        q [$];
  exp_t        e_m;
  logic [63:0] gotv [$];
  logic [63:0] frm [28][28];
  int          fw, fh, sel;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool2x2_layer1_if if4 ();
  maxpool2x2_layer1_if if28 ();
  maxpool2x2_layer1_if if5 ();

  assign if4.in_valid  = vld[0];
  assign if28.in_valid = vld[1];
  assign if5.in_valid  = vld[2];
  assign {if4.in_ch7, if4.in_ch6, if4.in_ch5, if4.in_ch4, if4.in_ch3, if4.in_ch2, if4.in_ch1, if4.in_ch0} = chv;
  assign {if28.in_ch7, if28.in_ch6, if28.in_ch5, if28.in_ch4, if28.in_ch3, if28.in_ch2, if28.in_ch1, if28.in_ch0} = chv;
  assign {if5.in_ch7, if5.in_ch6, if5.in_ch5, if5.in_ch4, if5.in_ch3, if5.in_ch2, if5.in_ch1, if5.in_ch0} = chv;
  assign ov  = {if5.out_valid, if28.out_valid, if4.out_valid};
  assign fdo = {if5.frame_done, if28.frame_done, if4.frame_done};
  assign od[0] = {if4.out_pool7, if4.out_pool6, if4.out_pool5, if4.out_pool4,
                  if4.out_pool3, if4.out_pool2, if4.out_pool1, if4.out_pool0};
  assign od[1] = {if28.out_pool7, if28.out_pool6, if28.out_pool5, if28.out_pool4,
                  if28.out_pool3, if28.out_pool2, if28.out_pool1, if28.out_pool0};
  assign od[2] = {if5.out_pool7, if5.out_pool6, if5.out_pool5, if5.out_pool4,
                  if5.out_pool3, if5.out_pool2, if5.out_pool1, if5.out_pool0};

  maxpool2x2_layer1 #(.IMG_W(4),  .IMG_H(4),  .CH(8)) u_dut4  (.clk(clk), .rst_n(rst_n), .pool_if(if4));
  maxpool2x2_layer1 #(.IMG_W(28), .IMG_H(28), .CH(8)) u_dut28 (.clk(clk), .rst_n(rst_n), .pool_if(if28));
  maxpool2x2_layer1 #(.IMG_W(5),  .IMG_H(5),  .CH(8)) u_dut5  (.clk(clk), .rst_n(rst_n), .pool_if(if5));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference window result computed directly from the stored frame.
  function automatic logic [63:0] ref_win(input int r, input int c);
    logic [63:0] res;
    logic [7:0]  a, b, x, y, m;
    logic [9:0]  s;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      a = frm[r-1][c-1][8*k +: 8];
      b = frm[r-1][c][8*k +: 8];
      x = frm[r][c-1][8*k +: 8];
      y = frm[r][c][8*k +: 8];
`ifdef MAXPOOL_AVG_EN
      s = 10'(a) + 10'(b) + 10'(x) + 10'(y);
      res[8*k +: 8] = 8'(s >> 2);
`else
      m = a;
      if (b > m) m = b;
      if (x > m) m = x;
      if (y > m) m = y;
      res[8*k +: 8] = m;
`endif
    end
    return res;
  endfunction

  task automatic drive_px(input int r, input int c, input bit gappy);
    exp_t e_d;
    @(negedge clk); #1;
    if (gappy) begin
      for (int g = 0; g < 8 && $urandom_range(1) == 0; g++) begin
        vld = '0;
        chv = {$urandom, $urandom};
        @(negedge clk); #1;
      end
    end
    vld = 3'(1 << sel);
    chv = frm[r][c];
    if ((r % 2 == 1) && (c % 2 == 1) && (r <= 2*(fh/2)-1) && (c <= 2*(fw/2)-1)) begin
      e_d.id   = sel;
      e_d.data = ref_win(r, c);
      e_d.fd   = (r == 2*(fh/2)-1) && (c == 2*(fw/2)-1);
      e_d.cyc  = cyc + 1;
      q.push_back(e_d);
    end
  endtask

  task automatic send_frame(input bit gappy);
    for (int r = 0; r < fh; r++)
      for (int c = 0; c < fw; c++)
        drive_px(r, c, gappy);
  endtask

  task automatic end_scn(input string tag, input int out0, input int fd0, input int n_exp, input int fd_exp);
    @(negedge clk); #1;
    vld = '0;
    repeat (4) @(negedge clk);
    chk({tag, "_pending"}, 64'(q.size()), 64'h0);
    chk({tag, "_count"}, 64'(nout[sel] - out0), 64'(n_exp));
    chk({tag, "_frame_done"}, 64'(nfd[sel] - fd0), 64'(fd_exp));
  endtask

  // Output monitor: reset values, hold behaviour and scoreboard compare.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        chk("reset_valid", 64'(ov[i]), 64'h0);
        chk("reset_pool", od[i], 64'h0);
        chk("reset_frame_done", 64'(fdo[i]), 64'h0);
        last[i] = '0;
      end else begin
        chk("frame_done_without_valid", 64'(fdo[i] & ~ov[i]), 64'h0);
        if (ov[i] === 1'b1) begin
          nout[i]++;
          if (fdo[i] === 1'b1) nfd[i]++;
          chk("unexpected_output", 64'(q.size() == 0), 64'h0);
          if (q.size() != 0) begin
            e_m = q.pop_front();
            chk("output_dut", 64'(i), 64'(e_m.id));
            chk("output_pool", od[i], e_m.data);
            chk("output_frame_done", 64'(fdo[i]), 64'(e_m.fd));
            chk("output_latency", 64'(cyc), 64'(e_m.cyc));
          end
          gotv.push_back(od[i]);
          last[i] = od[i];
        end else begin
          chk("hold_pool", od[i], last[i]);
        end
      end
    end
  end

  initial begin
    int o0, f0, g0, bad, p;
    logic [7:0] ramp_exp [4];
    logic [7:0] odd_exp [4];
`ifdef MAXPOOL_AVG_EN
    ramp_exp = '{8'd2, 8'd4, 8'd10, 8'd12};
    odd_exp  = '{8'd3, 8'd5, 8'd13, 8'd15};
`else
    ramp_exp = '{8'd5, 8'd7, 8'd13, 8'd15};
    odd_exp  = '{8'd6, 8'd8, 8'd16, 8'd18};
`endif
    sel = 0; fw = 4; fh = 4;

    // Reset held with random inputs
    repeat (5) begin
      @(negedge clk); #1;
      vld = 3'($urandom);
      chv = {$urandom, $urandom};
    end
    @(negedge clk); #1;
    vld = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 4x4 ramp on ch0, random other channels
    sel = 0; fw = 4; fh = 4;
    o0 = nout[sel]; f0 = nfd[sel]; g0 = gotv.size();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        frm[r][c] = {$urandom, $urandom};
        frm[r][c][7:0] = 8'(r*4 + c);
      end
    send_frame(1'b0);
    end_scn("ramp", o0, f0, 4, 1);
    for (int j = 0; j < 4; j++)
      if (g0 + j < gotv.size()) chk("ramp_ch0", 64'(gotv[g0+j][7:0]), 64'(ramp_exp[j]));

    // 28x28 channel independence, one 255 per window on ch3
    sel = 1; fw = 28; fh = 28;
    o0 = nout[sel]; f0 = nfd[sel]; g0 = gotv.size();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        for (int k = 0; k < 8; k++) frm[r][c][8*k +: 8] = 8'(k*30);
    for (int wr = 0; wr < 14; wr++)
      for (int wc = 0; wc < 14; wc++) begin
        p = $urandom_range(3);
        frm[2*wr + p/2][2*wc + p%2][31:24] = 8'hFF;
      end
    send_frame(1'b0);
    end_scn("chan_indep", o0, f0, 196, 1);
`ifndef MAXPOOL_AVG_EN
    bad = 0;
    for (int j = g0; j < gotv.size(); j++)
      for (int k = 0; k < 8; k++)
        if (gotv[j][8*k +: 8] !== ((k == 3) ? 8'hFF : 8'(k*30))) bad++;
    chk("chan_indep_values", 64'(bad), 64'h0);
`endif

    // Same frame with random input gaps
    o0 = nout[sel]; f0 = nfd[sel];
    send_frame(1'b1);
    end_scn("gappy", o0, f0, 196, 1);

    // Two back-to-back 4x4 frames, second = first + 1
    sel = 0; fw = 4; fh = 4;
    o0 = nout[sel]; f0 = nfd[sel];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 8; k++) frm[r][c][8*k +: 8] = 8'($urandom_range(254));
    send_frame(1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 8; k++) frm[r][c][8*k +: 8] = frm[r][c][8*k +: 8] + 8'd1;
    send_frame(1'b0);
    end_scn("back_to_back", o0, f0, 8, 2);

    // Reset after 10 pixels, then a fresh full frame
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) frm[r][c] = {$urandom, $urandom};
    for (int n = 0; n < 10; n++) drive_px(n / 4, n % 4, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    vld = '0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_pending", 64'(q.size()), 64'h0);
    o0 = nout[sel]; f0 = nfd[sel];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) frm[r][c] = {$urandom, $urandom};
    send_frame(1'b0);
    end_scn("after_reset", o0, f0, 4, 1);

    // 5x5 frame: last row and column ignored
    sel = 2; fw = 5; fh = 5;
    o0 = nout[sel]; f0 = nfd[sel]; g0 = gotv.size();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        frm[r][c] = {$urandom, $urandom};
        frm[r][c][7:0] = 8'(r*5 + c);
      end
    send_frame(1'b0);
    end_scn("odd_size", o0, f0, 4, 1);
    for (int j = 0; j < 4; j++)
      if (g0 + j < gotv.size()) chk("odd_size_ch0", 64'(gotv[g0+j][7:0]), 64'(odd_exp[j]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
